// File: rtl/dmem_lsu_master_if.sv
// Core-side request/response channel plus data-RAM port of the load/store master.
// The master modport is the LSU's view; slave is the core + RAM environment.
interface dmem_lsu_master_if #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [1:0]                req_size;
  logic                      req_unsigned;
  logic [31:0]               req_addr;
  logic [DATA_LENGTH-1:0]    req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_LENGTH-1:0]    resp_rdata;
  logic                      resp_err;
  logic                      mem_en;
  logic [3:0]                mem_we;
  logic [ADDRESS_LENGTH-1:0] mem_a;
  logic [DATA_LENGTH-1:0]    mem_di;
  logic [DATA_LENGTH-1:0]    mem_do;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_do,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_a, mem_di
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_do,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_a, mem_di
  );
endinterface

// File: rtl/dmem_lsu_master.sv
// Load/store initiator: one request at a time is turned into a single RAM access
// with byte-lane steering, and answered by one registered response.
module dmem_lsu_master #(
  parameter int          ADDRESS_LENGTH = 32,
  parameter int          DATA_LENGTH    = 32,
  parameter int unsigned MEM_WORDS      = 2048
) (
  input logic              CLK,
  input logic              RST_N,
  dmem_lsu_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t     state;
  logic       we_p0;
  logic       uns_p0;
  logic [1:0] size_p0;
  logic [1:0] lane_p0;

  logic [31:0] widx;
  logic        req_err;

  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   lane_we = 4'b0001 << lane;
      2'b01:   lane_we = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_we = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   steer_wdata = {4{wdata[7:0]}};
      2'b01:   steer_wdata = {2{wdata[15:0]}};
      default: steer_wdata = wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] lane,
                                          input logic uns, input logic [31:0] rdata);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    case (lane)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h  = lane[1] ? rdata[31:16] : rdata[15:0];
    bs = signed'(b);
    hs = signed'(h);
    case (size)
      2'b00:   extract = uns ? {24'd0, b} : 32'(bs);
      2'b01:   extract = uns ? {16'd0, h} : 32'(hs);
      default: extract = rdata;
    endcase
  endfunction

  assign widx = {2'b00, bus.req_addr[31:2]};

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (widx >= MEM_WORDS) req_err = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      we_p0          <= 1'b0;
      uns_p0         <= 1'b0;
      size_p0        <= 2'b00;
      lane_p0        <= 2'b00;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 4'b0000;
      bus.mem_a      <= '0;
      bus.mem_di     <= '0;
    end else begin
      case (state)
        // IDLE -> request capture; errors skip the RAM entirely
        IDLE: begin
          if (bus.req_valid) begin
            we_p0         <= bus.req_we;
            uns_p0        <= bus.req_unsigned;
            size_p0       <= bus.req_size;
            lane_p0       <= bus.req_addr[1:0];
            bus.req_ready <= 1'b0;
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state      <= ACCESS;
              bus.mem_en <= 1'b1;
              bus.mem_we <= bus.req_we ? lane_we(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
              bus.mem_a  <= ADDRESS_LENGTH'(bus.req_addr[31:2]);
              bus.mem_di <= bus.req_we ? steer_wdata(bus.req_size, bus.req_wdata) : '0;
            end
          end
        end
        // ACCESS -> RAM samples at this edge
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 4'b0000;
          if (we_p0) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
          end else begin
            state <= CAPTURE;
          end
        end
        // CAPTURE -> read data is only trusted here
        CAPTURE: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= extract(size_p0, lane_p0, uns_p0, bus.mem_do);
        end
        // RESP -> held until the consumer takes it
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_master.sv
// Directed bench for dmem_lsu_master with a behavioural 2048-word byte-enabled RAM.
module tb_dmem_lsu_master;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  dmem_lsu_master_if #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32)) bus ();

  dmem_lsu_master #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32), .MEM_WORDS(2048)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  logic [31:0] ram [0:2047];
  logic        ram_init = 1'b0;

  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < 2048; i++) ram[i] <= '0;
      ram_init    <= 1'b1;
      bus.mem_do  <= '0;
    end else if (bus.mem_en) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_we[k]) ram[bus.mem_a[10:0]][8*k +: 8] <= bus.mem_di[8*k +: 8];
      bus.mem_do <= ram[bus.mem_a[10:0]];
    end else begin
      bus.mem_do <= '0;
    end
  end

  int          en_cnt = 0;
  logic [3:0]  mon_we;
  logic [31:0] mon_a;
  logic [31:0] mon_di;

  always @(negedge CLK) begin
    if (bus.mem_en) begin
      en_cnt <= en_cnt + 1;
      mon_we <= bus.mem_we;
      mon_a  <= bus.mem_a;
      mon_di <= bus.mem_di;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input logic exp_en, input logic [3:0] exp_we, input logic [31:0] exp_di);
    int g;
    int lat;
    int en0;
    @(negedge CLK);
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge CLK);
      g++;
    end
    en0              = en_cnt;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    chk({tag, "_en_cnt"}, 32'(en_cnt - en0), 32'(exp_en));
    if (exp_en) begin
      chk({tag, "_mem_we"}, 32'(mon_we), 32'(exp_we));
      chk({tag, "_mem_a"}, mon_a, addr >> 2);
      if (we) chk({tag, "_mem_di"}, mon_di, exp_di);
    end
    if (bus.resp_ready) begin
      @(posedge CLK);
      #1;
    end
  endtask

  logic [31:0] held;
  int          en_hold;

  initial begin
    RST_N            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    access("s_w10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 4'hF, 32'hDEADBEEF);
    access("l_w10",  0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 1, 4'h0, 32'h0);
    access("s_b13",  1, 2'b00, 0, 32'h13, 32'hAAAAAA80, 32'h0,        0, 2, 1, 4'h8, 32'h80808080);
    access("l_sb13", 0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 3, 1, 4'h0, 32'h0);
    access("l_ub13", 0, 2'b00, 1, 32'h13, 32'h0,        32'h00000080, 0, 3, 1, 4'h0, 32'h0);
    access("l_w10b", 0, 2'b10, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0, 3, 1, 4'h0, 32'h0);
    access("l_sh12", 0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFF80AD, 0, 3, 1, 4'h0, 32'h0);
    access("l_ub11", 0, 2'b00, 1, 32'h11, 32'h0,        32'h000000BE, 0, 3, 1, 4'h0, 32'h0);
    access("s_h22",  1, 2'b01, 0, 32'h22, 32'hFFFF1234, 32'h0,        0, 2, 1, 4'hC, 32'h12341234);
    access("l_sh22", 0, 2'b01, 0, 32'h22, 32'h0,        32'h00001234, 0, 3, 1, 4'h0, 32'h0);
    access("e_h21",  0, 2'b01, 0, 32'h21, 32'h0,        32'h0,        1, 1, 0, 4'h0, 32'h0);
    access("e_w12",  0, 2'b10, 0, 32'h12, 32'h0,        32'h0,        1, 1, 0, 4'h0, 32'h0);
    access("e_w2000",1, 2'b10, 0, 32'h2000, 32'h12345678, 32'h0,      1, 1, 0, 4'h0, 32'h0);
    access("e_sz3",  0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 1, 0, 4'h0, 32'h0);
    access("l_w0",   0, 2'b10, 0, 32'h0,  32'h0,        32'h0,        0, 3, 1, 4'h0, 32'h0);
    access("s_w1ffc",1, 2'b10, 0, 32'h1FFC, 32'hCAFEF00D, 32'h0,      0, 2, 1, 4'hF, 32'hCAFEF00D);
    access("l_w1ffc",0, 2'b10, 0, 32'h1FFC, 32'h0,      32'hCAFEF00D, 0, 3, 1, 4'h0, 32'h0);

    // Response back-pressure with a competing request on the input
    bus.resp_ready = 1'b0;
    access("l_hold", 0, 2'b10, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0, 3, 1, 4'h0, 32'h0);
    held    = bus.resp_rdata;
    en_hold = en_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 32'h30;
      bus.req_wdata = 32'h11111111;
      @(posedge CLK);
      #1;
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, held);
      chk("hold_err", 32'(bus.resp_err), 32'd0);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge CLK);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("hold_release_valid", 32'(bus.resp_valid), 32'd0);
    chk("hold_release_ready", 32'(bus.req_ready), 32'd1);
    chk("hold_no_access", 32'(en_cnt - en_hold), 32'd0);
    access("l_w30",  0, 2'b10, 0, 32'h30, 32'h0,        32'h0,        0, 3, 1, 4'h0, 32'h0);

    // Reset landing in the ACCESS cycle of a store
    access("s_w40",  1, 2'b10, 0, 32'h40, 32'h0BADF00D, 32'h0,        0, 2, 1, 4'hF, 32'h0BADF00D);
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'h55555555;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    chk("rst_mid_access_en", 32'(bus.mem_en), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_mid_en_drop", 32'(bus.mem_en), 32'd0);
    chk("rst_mid_we_drop", 32'(bus.mem_we), 32'd0);
    @(posedge CLK);
    #1;
    chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    access("l_w40",  0, 2'b10, 0, 32'h40, 32'h0,        32'h0BADF00D, 0, 3, 1, 4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_master.md
Name: dmem_lsu_master

Overview:
- Load/store initiator that turns core data-memory requests into accesses on the 2048-word byte-enabled synchronous data RAM port (CLK, WE[3:0], EN, Di, Do, A).
- Handles byte, half and word sizes, byte-lane steering, sign/zero extension, misalignment and range checks.
- Returns one registered response per request over a valid/ready handshake.
- Sits between the core's MEM stage and the data RAM.

Parameters:
- ADDRESS_LENGTH, 32, width of mem_a (RAM word index).
- DATA_LENGTH, 32, data width. Only 32 is supported.
- MEM_WORDS, 2048, number of RAM words. A word index at or above this value is an access error.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal-size or out-of-range access.
- mem_en  out  1  to RAM EN.
- mem_we  out  4  to RAM WE.
- mem_a  out  ADDRESS_LENGTH  to RAM A (req_addr[31:2], zero-extended or truncated).
- mem_di  out  32  to RAM Di.
- mem_do  in  32  from RAM Do.

Behaviour:
- Reset: state goes to IDLE asynchronously. All outputs are 0 except req_ready, which is 1 in IDLE. All internal request registers are cleared.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- Handshakes:
  - req_ready = (state==IDLE).
  - A request is accepted at edge E0 when req_valid && req_ready. All request fields are registered at E0.
  - resp_valid = (state==RESP). resp_rdata and resp_err are held stable until resp_valid && resp_ready. At that edge the FSM returns to IDLE.
  - No new request is accepted while a response is pending.
- Error check, evaluated at E0 (no RAM access, mem_en stays 0):
  - req_size==11 → error.
  - Half access with addr[0]==1 → error.
  - Word access with addr[1:0]!=0 → error.
  - addr[31:2] >= MEM_WORDS → error.
  - On error: IDLE goes directly to RESP with resp_err=1 and resp_rdata=0. resp_valid is high in the cycle after E0.
- ACCESS state (exactly one cycle): mem_en=1 and mem_a=word index. mem_en and mem_we are 0 in every other state.
  - Store byte at lane k=addr[1:0]: mem_we = 1<<k, mem_di = {4{wdata[7:0]}}.
  - Store half: mem_we = 0011 (addr[1]=0) or 1100 (addr[1]=1), mem_di = {2{wdata[15:0]}}.
  - Store word: mem_we = 1111, mem_di = wdata.
  - Load: mem_we = 0000.
- The RAM samples at edge E1 (end of ACCESS).
  - Store: ACCESS → RESP. resp_valid is high after E1 (store latency 2 cycles from acceptance).
  - Load: ACCESS → CAPTURE. mem_do is valid during CAPTURE. It is sampled at E2, lane-selected and extended into resp_rdata. CAPTURE → RESP, so resp_valid is high after E2 (load latency 3 cycles).
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: lane half addr[1].
  - Word: as-is.
  - Sign- or zero-extend to 32 bits per req_unsigned.
- mem_do is ignored outside CAPTURE. The RAM drives Do=0 when EN=0, and that value must never reach resp_rdata.
- Reset mid-operation:
  - RST_N low during ACCESS drops mem_en and mem_we immediately, so no write occurs at the next edge.
  - A pending response is discarded.
  - After release, the block is in IDLE with req_ready=1.
- resp_ready may be held high constantly. Back-to-back requests then complete every 3 (store) or 4 (load) cycles.

Test Plan:
- Store word 0xDEADBEEF at 0x0000_0010, then load word at 0x10 → ACCESS drives mem_we=1111 and mem_a=4. Load response is 0xDEADBEEF with resp_err=0. resp_valid rises 2 and 3 cycles after acceptance respectively.
- Store byte 0x80 at 0x13, then signed byte load at 0x13, then unsigned byte load at 0x13 → mem_we=1000 and mem_di=0x80808080. Responses are 0xFFFFFF80 and 0x00000080. Word load at 0x10 returns 0x80ADBEEF.
- Store half 0x1234 at 0x22, then signed half load at 0x22 → mem_we=1100 and mem_di=0x12341234. Response is 0x00001234.
- Errors:
  - Half load at 0x21 → resp_err=1 and resp_rdata=0 one cycle after acceptance, with mem_en never high.
  - Word store at 0x2000 (index 2048) → resp_err=1 and no write.
  - req_size=11 → resp_err=1.
- Hold resp_ready=0 for 5 cycles after a load response → resp_valid, resp_rdata and resp_err stay stable. req_ready stays 0 and a concurrent req_valid is not accepted. Raising resp_ready returns the FSM to IDLE.
- Assert RST_N=0 during the ACCESS cycle of a word store of 0x55555555 to 0x40 → mem_en drops immediately. A later word load at 0x40 returns the prior contents, not 0x55555555.
